// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Two-requester arbiter for the register file's single write port. Port 0
// has fixed priority. Port 1 takes over after MAX_WAIT consecutive lost
// contended cycles. Writes pass through one registered output stage. A
// pending-write scoreboard (busy_mask) is set by the issue logic and is
// cleared when the output stage commits a write.
module regfile_write_arbiter #(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_reg,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_reg,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_reg,
  output logic        regWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic [31:0] busy_mask
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] busy_q, busy_d;

  logic        grant0, grant1, xfer;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;

  // Grant decision: depends only on the valids, the starvation count and reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      grant1 = req1_valid && (!req0_valid || (wait_cnt_q == MAX_WAIT_C));
      grant0 = req0_valid && !grant1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 | grant1;
  assign sel_reg    = grant1 ? req1_reg  : req0_reg;
  assign sel_data   = grant1 ? req1_data : req0_data;

  // Next-state for starvation counter, output stage and scoreboard.
  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    busy_d       = busy_q;

    if (!req1_valid || grant1) begin
      wait_cnt_d = '0;
    end else if (req0_valid && grant0 && (wait_cnt_q != MAX_WAIT_C)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    // x0 transfers are accepted and loaded but never raise the write enable.
    if (xfer) begin
      reg_write_d  = (sel_reg != 5'd0);
      write_reg_d  = sel_reg;
      write_data_d = sel_data;
    end

    // Clear first so a same-edge allocation of the same register wins.
    if (reg_write_q) begin
      busy_d[write_reg_q] = 1'b0;
    end
    if (alloc_valid && (alloc_reg != 5'd0)) begin
      busy_d[alloc_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous clear; an in-flight write is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q   <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  assign regWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;
  assign busy_mask = busy_q;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters: port 0 (ALU/immediate results) and port 1 (load/multi-cycle results). Arbitrates with fixed priority for port 0 and a bounded-starvation override for port 1. Drives the register file's `regWrite`/`writeReg`/`writeData` from a registered output stage. Keeps a 32-bit pending-write scoreboard that the issue logic uses to stall reads of registers with in-flight results.

## Interface
- `MAX_WAIT`, default 3: number of consecutive lost contended cycles after which port 1 takes priority. Legal range is 1..15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `req0_valid`  in  1  port 0 has a result.
- `req0_reg`  in  5  port 0 destination register.
- `req0_data`  in  32  port 0 result.
- `req0_ready`  out  1  port 0 accepted this cycle (combinational).
- `req1_valid`, `req1_reg`, `req1_data`, `req1_ready`: same as port 0, for port 1.
- `alloc_valid`  in  1  issue logic marks a destination as pending.
- `alloc_reg`  in  5  register to mark.
- `regWrite`  out  1  registered write enable to the register file.
- `writeReg`  out  5  registered write address.
- `writeData`  out  32  registered write data.
- `busy_mask`  out  32  registered pending-write scoreboard; bit i means xi has an outstanding write.

## Operation
- **Handshake.** A transfer happens on port N when `reqN_valid & reqN_ready` is high at a rising edge. The requester holds `reg`/`data` stable while valid and not ready. `ready` never depends on anything except the valid inputs, `wait_cnt` and `reset`.
- **Grant rules.**
  - Only one valid: that port gets ready=1.
  - Both valid: port 1 wins if `wait_cnt == MAX_WAIT`, otherwise port 0 wins.
  - Neither valid: both ready=0.
  - While `reset` is high: both ready=0.
- **Starvation counter** `wait_cnt`, width 4, internal:
  - +1 when both ports are valid and port 0 is granted.
  - Cleared when port 1 is granted or when `req1_valid` is 0.
  - Otherwise holds.
  - Saturates at `MAX_WAIT`.
- **Output stage.** On a transfer, load `writeReg`/`writeData` from the granted port. `regWrite` is set to 1 unless the destination is x0.
  - An x0 transfer is accepted and discarded: `regWrite`=0 and `busy_mask` is unaffected.
  - With no transfer, `regWrite` is 0 next cycle. `writeReg`/`writeData` hold their last value.
- **Scoreboard.**
  - Set: at an edge with `alloc_valid` high and `alloc_reg` != 0, set `busy_mask[alloc_reg]`.
  - Clear: at an edge with `regWrite` high (output stage), clear `busy_mask[writeReg]`. This is the same edge the register file commits the write.
  - Set and clear of the same bit at the same edge: set wins, because a new producer supersedes the old one.
  - Bit 0 is always 0.
  - Allocating an already-set bit leaves it set. No counting.
- **Reset.** Asynchronous and effective mid-transfer. All of the following go to 0 immediately: `regWrite`, `writeReg`, `writeData`, `busy_mask`, `wait_cnt`, both `ready`. An in-flight output-stage write is dropped.

## Timing
- Latency: a transfer at edge N gives `regWrite`/`writeReg`/`writeData` valid through cycle N..N+1. The register file commits at edge N+1, and the `busy_mask` bit clears at edge N+1.
- Throughput: one write per cycle total across both ports.
- Worst-case port 1 wait under continuous port 0 traffic is `MAX_WAIT` lost cycles. It is granted on the next contended cycle.
- `busy_mask` reflects allocations one cycle after the `alloc_valid` edge.

## Test plan
- **Single write.** Reset, then `alloc` x5, then `req0` (x5, 0xDEADBEEF) for one cycle.
  - `busy_mask` = 0x00000020 after the alloc edge.
  - `req0_ready`=1.
  - Next cycle `regWrite`=1, `writeReg`=5, `writeData`=0xDEADBEEF.
  - `busy_mask` = 0 after the following edge.
- **x0 discard.** `req1` (x0, 0x1).
  - `req1_ready`=1.
  - `regWrite` stays 0 and `busy_mask` is unchanged.
  - `alloc` x0 leaves `busy_mask` = 0.
- **Starvation, MAX_WAIT=3.** Hold both valid for 8 cycles.
  - Grants: 0,0,0,1,0,0,0,1.
  - `wait_cnt` sequence: 0,1,2,3,0,1,2,3.
  - `writeReg` follows the granted port's register one cycle later.
- **Set/clear collision.** x7 is pending and its write is in the output stage (`regWrite`=1, `writeReg`=7). Assert `alloc` x7 on that same edge.
  - `busy_mask[7]` remains 1.
- **Back-to-back.** `req0` to x1, x2, x3 on consecutive cycles with valid held.
  - `regWrite` is high for 3 consecutive cycles.
  - `writeReg` = 1, 2, 3.
  - Bits 1..3 clear one per edge.
- **Async reset mid-transfer.** Assert `reset` between edges while `regWrite`=1 and `busy_mask`=0x0000000E.
  - All outputs go to 0 before the next edge.
  - Both readies are 0 while reset is held.
  - Normal arbitration resumes on the first edge after release.
